// File: rtl/onehot_sched_pkg.sv
// onehot_sched_pkg: shared state encoding and sizing helpers for the one-hot fill scheduler.
package onehot_sched_pkg;
    typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE, S_ERROR} sched_state_e;
    localparam int N_DEF = 105;
    localparam int STALL_MAX_DEF = 16;
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
    localparam int PTR_W = ptr_w(N_DEF);
endpackage

// File: rtl/rr_onehot_picker.sv
// rr_onehot_picker: combinational round-robin search for the first set bit of elig
// at or above ptr, wrapping from N-1 to 0; returns one-hot pick, its index and found.
module rr_onehot_picker #(
    parameter int N  = 8,
    parameter int PW = 3
) (
    input  logic [N-1:0]  elig,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  pick,
    output logic [PW-1:0] idx,
    output logic          found
);
    logic [N-1:0] rot;
    // rotating the doubled vector puts the bit at ptr in position 0
    assign rot = N'({elig, elig} >> ptr);
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                found = 1'b1;
                idx   = PW'((int'(ptr) + k) % N);
            end
        end
    end
    assign pick = found ? ({{(N-1){1'b0}}, 1'b1} << idx) : '0;
endmodule

// File: rtl/onehot_fill_scheduler.sv
// onehot_fill_scheduler: issues pending fill requests one bit per cycle in round-robin order,
// holding back the gated bit until a prerequisite bit has been latched for a full cycle.
module onehot_fill_scheduler
    import onehot_sched_pkg::*;
#(
    parameter int N         = N_DEF,
    parameter int GATED_IDX = 89,
    parameter int PRE_A     = 96,
    parameter int PRE_B     = 101,
    parameter int STALL_MAX = STALL_MAX_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         abort,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant,
    output logic         grant_valid,
    output logic [N-1:0] mask,
    output logic         busy,
    output logic         done,
    output logic         blocked,
    output logic         err
);
    localparam int PW = ptr_w(N);
    localparam int SW = $clog2(STALL_MAX + 1);

    sched_state_e  state, state_nx;
    logic [PW-1:0] ptr, idx;
    logic [SW-1:0] stall, stall_nx;
    logic          pre_seen_q, found;
    logic [N-1:0]  pend, elig, pick, mask_nx;

    assign pend = req & ~mask;
    always_comb begin
        elig = pend;
        elig[GATED_IDX] = pend[GATED_IDX] & pre_seen_q;
    end

    rr_onehot_picker #(.N(N), .PW(PW)) u_picker (
        .elig  (elig),
        .ptr   (ptr),
        .pick  (pick),
        .idx   (idx),
        .found (found)
    );

    assign mask_nx  = mask | pick;
    assign stall_nx = found ? '0 : (stall == SW'(STALL_MAX) ? stall : stall + SW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_FILL: begin
                if (abort)                                                state_nx = S_IDLE;
                else if (found && &mask_nx)                               state_nx = S_DONE;
                else if (!found && stall_nx == SW'(STALL_MAX) && !(&mask)) state_nx = S_ERROR;
            end
            default: if (start) state_nx = S_FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant       <= '0;
            grant_valid <= 1'b0;
            mask        <= '0;
            ptr         <= '0;
            pre_seen_q  <= 1'b0;
            stall       <= '0;
        end else begin
            grant       <= '0;
            grant_valid <= 1'b0;
            pre_seen_q  <= mask[PRE_A] | mask[PRE_B];
            if (state != S_FILL) begin
                if (start) begin
                    mask       <= '0;
                    ptr        <= '0;
                    pre_seen_q <= 1'b0;
                    stall      <= '0;
                end
            end else if (!abort) begin
                stall <= stall_nx;
                if (found) begin
                    grant       <= pick;
                    grant_valid <= 1'b1;
                    mask        <= mask_nx;
                    ptr         <= (idx == PW'(N - 1)) ? '0 : idx + PW'(1);
                end
            end
        end
    end

    assign busy    = (state == S_FILL);
    assign done    = (state == S_DONE);
    assign err     = (state == S_ERROR);
    assign blocked = busy & pend[GATED_IDX] & ~pre_seen_q & ~|elig;
endmodule
